// File: rtl/fpu_mul_round_sp.sv
// fpu_mul_round_sp: normalize then round/pack stage of a single-precision multiplier, 2-deep valid/ready pipe.
// Define FPU_MUL_ROUND_EN for round-to-nearest-even; when undefined the fraction is truncated.
module fpu_mul_round_sp #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [9:0]       in_exp,
    input  logic [47:0]      in_mant,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             underflow,
    output logic             inexact
);
    localparam int unsigned EXP_W  = 10;
    // Two extra exponent bits so the +1 adjustments can never wrap before the range checks
    localparam int unsigned XW     = EXP_W + 2;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned SUM_W  = FRAC_W + 1;
    localparam logic [XW-1:0] EXP_MAX = XW'(255);

    typedef struct packed {
        logic              sign;
        logic              zero;
        logic [XW-1:0]     exp;
        logic [FRAC_W-1:0] frac;
        logic              guard;
        logic              sticky;
    } s1_t;

    logic             s1_valid_q;
    logic             s2_valid_q;
    logic             s1_adv;
    s1_t              s1_d;
    s1_t              s1_q;
    logic             round_up;
    logic [SUM_W-1:0] frac_sum;
    logic [XW-1:0]    exp_fin;
    logic [31:0]      res_d;
    logic             ovf_d;
    logic             unf_d;
    logic             inx_d;
    logic [WIDTH-1:0] result_q;
    logic             ovf_q;
    logic             unf_q;
    logic             inx_q;

    assign s1_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;

    // S1: pick the leading-one position and split into fraction, guard and sticky
    always_comb begin
        s1_d      = '0;
        s1_d.sign = in_sign;
        s1_d.zero = (in_mant[47:46] == 2'b00);
        s1_d.exp  = {{(XW-EXP_W){in_exp[EXP_W-1]}}, in_exp} + XW'(in_mant[47]);
        if (in_mant[47]) begin
            s1_d.frac   = in_mant[46:24];
            s1_d.guard  = in_mant[23];
            s1_d.sticky = |in_mant[22:0];
        end else begin
            s1_d.frac   = in_mant[45:23];
            s1_d.guard  = in_mant[22];
            s1_d.sticky = |in_mant[21:0];
        end
    end

    // S2: round, absorb the carry into the exponent, then range-check and pack
    always_comb begin
        round_up = 1'b0;
`ifdef FPU_MUL_ROUND_EN
        round_up = s1_q.guard && (s1_q.sticky || s1_q.frac[0]);
`endif
        frac_sum = {1'b0, s1_q.frac} + SUM_W'(round_up);
        exp_fin  = s1_q.exp + XW'(frac_sum[FRAC_W]);
        res_d    = {s1_q.sign, exp_fin[7:0], frac_sum[FRAC_W-1:0]};
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        inx_d    = s1_q.guard || s1_q.sticky;
        if (s1_q.zero) begin
            res_d = {s1_q.sign, 31'b0};
            inx_d = 1'b0;
        end else if ($signed(exp_fin) >= $signed(EXP_MAX)) begin
            res_d = {s1_q.sign, 8'hFF, 23'h0};
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end else if (exp_fin[XW-1] || (exp_fin == '0)) begin
            res_d = {s1_q.sign, 31'b0};
            unf_d = 1'b1;
            inx_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inx_q      <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_q <= s1_d;
            end
            if (s1_adv) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s1_adv && s1_valid_q) begin
                result_q <= WIDTH'(res_d);
                ovf_q    <= ovf_d;
                unf_q    <= unf_d;
                inx_q    <= inx_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign inexact   = inx_q;

endmodule

// File: tb/tb_fpu_mul_round_sp.sv
// Scoreboard bench for fpu_mul_round_sp: directed corner products, back-pressure, reset flush, random traffic.
module tb_fpu_mul_round_sp;
    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
        bit          chk_lat;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    bit          rnd_en = 1'b0;
    bit          rnd_bit = 1'b1;
    logic        ready_force = 1'b1;
    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;

`ifdef FPU_MUL_ROUND_EN
    localparam logic [31:0] E_RUP = 32'h40000002;
    localparam logic [31:0] E_CRY = 32'h40800000;
`else
    localparam logic [31:0] E_RUP = 32'h40000001;
    localparam logic [31:0] E_CRY = 32'h407FFFFF;
`endif

    assign out_ready = rnd_en ? rnd_bit : ready_force;

    fpu_mul_round_sp #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        rnd_bit = ($urandom_range(0, 9) < 6);
    end

    // Reference: value-level rounding on the discarded remainder vs. one half ulp
    function automatic exp_t model(input logic s, input logic [9:0] e, input logic [47:0] m);
        exp_t   r;
        longint ex;
        longint kept;
        longint rem;
        longint half;
        int     sh;
        bit     up;
        r.res = {s, 31'b0}; r.ovf = 1'b0; r.unf = 1'b0; r.inx = 1'b0;
        r.chk_lat = 1'b0; r.acc_cyc = 0;
        if (m[47:46] == 2'b00) return r;
        sh   = m[47] ? 24 : 23;
        ex   = longint'($signed(e)) + (m[47] ? 64'sd1 : 64'sd0);
        kept = longint'(m >> sh);
        rem  = longint'(m) & ((64'sd1 <<< sh) - 64'sd1);
        half = 64'sd1 <<< (sh - 1);
        up   = 1'b0;
`ifdef FPU_MUL_ROUND_EN
        up = (rem > half) || ((rem == half) && ((kept % 2) == 1));
`endif
        if (up) kept = kept + 1;
        if (kept >= (64'sd1 <<< 24)) begin
            kept = kept / 2;
            ex   = ex + 1;
        end
        r.inx = (rem != 0);
        if (ex >= 255) begin
            r.res = {s, 8'hFF, 23'h0}; r.ovf = 1'b1; r.inx = 1'b1;
        end else if (ex <= 0) begin
            r.res = {s, 31'b0}; r.unf = 1'b1; r.inx = 1'b1;
        end else begin
            r.res = {s, 8'(ex), 23'(kept)};
        end
        return r;
    endfunction

    function automatic exp_t mk(input logic [31:0] res, input logic o, input logic u, input logic x);
        exp_t r;
        r.res = res; r.ovf = o; r.unf = u; r.inx = x; r.chk_lat = 1'b1; r.acc_cyc = 0;
        return r;
    endfunction

    function automatic logic [47:0] rnd_mant();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 9))
            0:       r[47:46] = 2'b00;
            1, 2:    r[47:46] = 2'b01;
            3:       begin r[47] = 1'b1; r[23:0] = 24'h800000; end
            4:       begin r[47:46] = 2'b01; r[22:0] = 23'h400000; end
            5:       begin r[47:24] = 24'hFFFFFF; r[23] = 1'b1; end
            default: r[47] = 1'b1;
        endcase
        return r[47:0];
    endfunction

    function automatic logic [9:0] rnd_exp();
        case ($urandom_range(0, 9))
            0:       return 10'($urandom_range(250, 258));
            1:       return 10'(2 - int'($urandom_range(0, 6)));
            2:       return 10'($urandom);
            default: return 10'($urandom_range(1, 253));
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, want);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the product is accepted
    task automatic send(input logic s, input logic [9:0] e, input logic [47:0] m, input exp_t x);
        bit done = 1'b0;
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                x.acc_cyc = cyc;
                sb.push_back(x);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: in_ready never high, want accept");
        end
    endtask

    task automatic send_rnd();
        logic        s;
        logic [9:0]  e;
        logic [47:0] m;
        s = 1'($urandom); e = rnd_exp(); m = rnd_mant();
        send(s, e, m, model(s, e, m));
    endtask

    task automatic wait_drain();
        int i = 0;
        while (sb.size() != 0 && i < 3000) begin
            @(posedge clk);
            i++;
        end
        if (sb.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: %0d outstanding, want 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: whenever a result is presented compare it to the head; pop on transfer
    initial begin : monitor
        bit   seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (out_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: got res=%h, want no output", result);
                end else begin
                    e = sb[0];
                    if (result !== e.res || overflow !== e.ovf || underflow !== e.unf || inexact !== e.inx) begin
                        n_err++;
                        $display("FAIL output: got res=%h ovf/unf/inx=%b%b%b, want res=%h ovf/unf/inx=%b%b%b",
                                 result, overflow, underflow, inexact, e.res, e.ovf, e.unf, e.inx);
                    end
                    if (!seen && e.chk_lat) begin
                        n_cmp++;
                        if (cyc != e.acc_cyc + 2) begin
                            n_err++;
                            $display("FAIL latency: got %0d cycles, want 2", cyc - e.acc_cyc);
                        end
                    end
                    seen = 1'b1;
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : main
        rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", 32'({overflow, underflow, inexact}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed corner products with downstream always ready
        send(1'b0, 10'd127, 48'h900000000000, mk(32'h40100000, 1'b0, 1'b0, 1'b0));
        send(1'b0, 10'd127, 48'h800001800000, mk(E_RUP, 1'b0, 1'b0, 1'b1));
        send(1'b0, 10'd127, 48'h800000800000, mk(32'h40000000, 1'b0, 1'b0, 1'b1));
        send(1'b0, 10'd127, 48'hFFFFFF800000, mk(E_CRY, 1'b0, 1'b0, 1'b1));
        send(1'b1, 10'd254, 48'h800000000000, mk(32'hFF800000, 1'b1, 1'b0, 1'b1));
        send(1'b1, 10'h3FB, 48'h800000000000, mk(32'h80000000, 1'b0, 1'b1, 1'b1));
        send(1'b1, 10'd127, 48'h200000000000, mk(32'h80000000, 1'b0, 1'b0, 1'b0));
        wait_drain();

        // Four products against a 3-cycle downstream stall
        ready_force = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++) send_rnd();
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                @(posedge clk);
                #1;
                ready_force = 1'b1;
            end
        join
        wait_drain();

        // Reset with both stages occupied discards everything in flight
        ready_force = 1'b0;
        send_rnd();
        send_rnd();
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_result", result, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_force = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_idle", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(1'b0, 10'd127, 48'h900000000000, mk(32'h40100000, 1'b0, 1'b0, 1'b0));
        wait_drain();

        // Random traffic with random back-pressure and input gaps
        rnd_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            repeat ($urandom_range(0, 3) == 0 ? 1 : 0) begin
                @(posedge clk);
                #1;
            end
            send_rnd();
        end
        rnd_en = 1'b0;
        ready_force = 1'b1;
        wait_drain();
        repeat (3) begin
            @(negedge clk);
            check("final_idle", 32'(out_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
